// File: rtl/if1_btb_if.sv
// Fetch-side bus of the IF1 branch target buffer: the lookup PC, the
// registered prediction, the IF2 predecoder correction and the EX resolution.
interface if1_btb_if;
  logic        stall;
  logic [31:0] pc;
  logic [33:0] brtype_pcpre;
  logic [31:0] pred_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [33:0] upd_type_pcpre;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;

  // Fetch unit / pipeline side
  modport master (
    output stall, pc, upd_valid, upd_pc, upd_type_pcpre,
           ex_valid, ex_pc, ex_taken, ex_target,
    input  brtype_pcpre, pred_pc
  );

  // Branch target buffer side
  modport slave (
    input  stall, pc, upd_valid, upd_pc, upd_type_pcpre,
           ex_valid, ex_pc, ex_taken, ex_target,
    output brtype_pcpre, pred_pc
  );
endinterface

// File: rtl/if1_btb.sv
// Direct-mapped branch target buffer for IF1. Looks up the fetch PC, registers
// {type, next_pc} for IF2, and is trained by IF2 predecode corrections and EX
// branch resolutions. IF2 wins when both hit the same entry in one cycle.
module if1_btb #(
  parameter int IDX_W = 4
) (
  input  logic     clk,
  input  logic     rstn,
  if1_btb_if.slave bus
);
  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  logic             valid_q [N];
  logic [TAG_W-1:0] tag_q   [N];
  logic [1:0]       type_q  [N];
  logic [31:0]      tgt_q   [N];
  logic [1:0]       cnt_q   [N];

  logic [33:0] pred_p1;
  logic [31:0] pc_p1;

  function automatic logic [1:0] cnt_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] cnt_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // Lookup decode
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [31:0]      pc_inc;
  logic             lk_hit;
  logic [33:0]      pred_p0;

  assign lk_idx = bus.pc[IDX_W+1:2];
  assign lk_tag = bus.pc[31:IDX_W+2];
  assign pc_inc = bus.pc + 32'd4;

  // Next prediction from the pre-write table contents
  always_comb begin
    pred_p0 = {2'b00, pc_inc};
    lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    if (lk_hit) begin
      case (type_q[lk_idx])
        2'b10, 2'b11: pred_p0 = {type_q[lk_idx], tgt_q[lk_idx]};
        2'b01:        pred_p0 = cnt_q[lk_idx][1] ? {2'b01, tgt_q[lk_idx]}
                                                 : {2'b01, pc_inc};
        default:      pred_p0 = {2'b00, pc_inc};
      endcase
    end
  end

  // Update decode
  logic [IDX_W-1:0] u_idx, e_idx;
  logic [TAG_W-1:0] u_tag, e_tag;
  logic [1:0]       u_type;
  logic [31:0]      u_fact;
  logic             u_seq, u_wr, u_inv;
  logic             e_hit, e_blk, e_cond, e_tgt;
  logic             unused_ex_lo;

  assign u_idx  = bus.upd_pc[IDX_W+1:2];
  assign u_tag  = bus.upd_pc[31:IDX_W+2];
  assign u_type = bus.upd_type_pcpre[33:32];
  assign u_fact = bus.upd_type_pcpre[31:0];
  assign u_seq  = (u_fact == bus.upd_pc + 32'd4);
  assign e_idx  = bus.ex_pc[IDX_W+1:2];
  assign e_tag  = bus.ex_pc[31:IDX_W+2];
  assign unused_ex_lo = ^bus.ex_pc[1:0];

  // Classify this cycle's IF2 and EX table updates
  always_comb begin
    u_wr   = bus.upd_valid && (u_type != 2'b00);
    u_inv  = bus.upd_valid && (u_type == 2'b00) &&
             valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    e_hit  = bus.ex_valid && valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    e_blk  = bus.upd_valid && (u_idx == e_idx);
    e_cond = e_hit && !e_blk && (type_q[e_idx] == 2'b01);
    e_tgt  = e_hit && !e_blk && bus.ex_taken &&
             ((type_q[e_idx] == 2'b01) || (type_q[e_idx] == 2'b11));
  end

  // Entry valid bits and direction counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= 2'b01;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (u_wr && (u_idx == IDX_W'(i))) begin
          valid_q[i] <= 1'b1;
          if (u_type == 2'b01) cnt_q[i] <= u_seq ? 2'b01 : 2'b10;
        end else if (u_inv && (u_idx == IDX_W'(i))) begin
          valid_q[i] <= 1'b0;
        end else if (e_cond && (e_idx == IDX_W'(i))) begin
          cnt_q[i] <= bus.ex_taken ? cnt_inc(cnt_q[i]) : cnt_dec(cnt_q[i]);
        end
      end
    end
  end

  // Entry tag, type and target; meaningless until valid is set
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (u_wr && (u_idx == IDX_W'(i))) begin
        tag_q[i]  <= u_tag;
        type_q[i] <= u_type;
        if ((u_type != 2'b01) || !u_seq) tgt_q[i] <= u_fact;
      end else if (e_tgt && (e_idx == IDX_W'(i))) begin
        tgt_q[i] <= bus.ex_target;
      end
    end
  end

  // ---- p0 -> p1: prediction register toward IF2, held on stall ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pred_p1 <= 34'h0;
      pc_p1   <= 32'h0;
    end else if (!bus.stall) begin
      pred_p1 <= pred_p0;
      pc_p1   <= bus.pc;
    end
  end

  assign bus.brtype_pcpre = pred_p1;
  assign bus.pred_pc      = pc_p1;
endmodule

// File: doc/if1_btb.md
IF1_BTB -- requirements
Module: IF1_BTB

Interface
REQ-001 Parameter IDX_W, default 4, index width; the table holds 2**IDX_W entries.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 stall  input  1  fetch stall; holds the output registers.
REQ-005 pc  input  32  IF1 fetch PC, word-aligned.
REQ-006 brtype_pcpre  output  34  registered prediction {type[1:0], next_pc[31:0]} for the instruction now in IF2; type codes: 00 other, 01 b/conditional, 10 bl, 11 jirl.
REQ-007 pred_pc  output  32  registered copy of the pc that produced brtype_pcpre.
REQ-008 upd_valid  input  1  IF2 predecoder flush/correction strobe.
REQ-009 upd_pc  input  32  PC of the corrected instruction.
REQ-010 upd_type_pcpre  input  34  corrected {type, PC_fact} from the predecoder.
REQ-011 ex_valid  input  1  EX branch resolution strobe.
REQ-012 ex_pc  input  32  PC of the resolved branch.
REQ-013 ex_taken  input  1  resolved direction.
REQ-014 ex_target  input  32  resolved target.

Function
REQ-015 Direct-mapped table; index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2]; each entry holds valid, tag, type[1:0], target[31:0] and a 2-bit saturating counter.
REQ-016 Hit = entry valid and tag equal.
REQ-017 Combinational next prediction:
- hit with type 10 or 11 -> {type, target}
- hit with type 01 -> {01, target} if counter[1]=1, else {01, pc+4}
- miss -> {00, pc+4}; addition is modulo 2**32.
REQ-018 On each clk edge with stall=0, brtype_pcpre and pred_pc load the next prediction and pc, giving 1-cycle latency; with stall=1 both hold.
REQ-019 IF2 write: upd_valid=1 with upd type != 00 writes entry[index(upd_pc)] as follows:
- valid=1, tag, type set from the update
- for type 10/11: target = PC_fact
- for type 01 with PC_fact != upd_pc+4: target = PC_fact, counter = 10
- for type 01 with PC_fact == upd_pc+4: target unchanged, counter = 01
REQ-020 IF2 invalidate: upd_valid=1 with upd type 00 clears valid of the indexed entry only if its tag matches upd_pc; otherwise no change.
REQ-021 EX update on hit, type 01: counter increments (saturating at 11) when ex_taken=1 and decrements (saturating at 00) when ex_taken=0; on ex_taken=1, target = ex_target.
REQ-022 EX update on hit, type 11 with ex_taken=1: target = ex_target; counter unchanged.
REQ-023 EX update on miss, or on hit with type 10: no change.
REQ-024 Simultaneous IF2 and EX updates to the same index: only the IF2 write/invalidate takes effect. Different indices: both take effect in the same cycle.
REQ-025 Table writes occur regardless of stall.
REQ-026 A lookup in the same cycle as a write to the same index reads the pre-write contents; there is no bypass.
REQ-027 All table state is in flops and is fully synthesizable; no memory macros.

Reset
REQ-028 While rstn=0: all entry valid bits are 0, all counters are 01, brtype_pcpre = 34'h0, and pred_pc = 32'h0.
REQ-029 Reset asserted mid-operation clears state immediately, without waiting for a clock edge.
REQ-030 The first edge after release with stall=0 loads a miss prediction for the presented pc.

Verification
REQ-031 Cold lookup: reset, pc=0x1C000000 -> next cycle brtype_pcpre={00,0x1C000004}, pred_pc=0x1C000000.
REQ-032 Allocate bl: upd_valid with upd_pc=0x1C000010, upd_type_pcpre={10,0x1C000100}; later pc=0x1C000010 -> {10,0x1C000100}. pc=0x1C000050 (same index, different tag) -> {00,0x1C000054}.
REQ-033 Counter training:
- allocate a conditional at 0x1C000020 with PC_fact=0x1C000008 -> {01,0x1C000008}
- two EX not-taken updates -> {01,0x1C000024}
- three EX taken updates with target 0x1C000008 -> {01,0x1C000008}
- a fourth taken update leaves the counter at 11
REQ-034 Collision: same cycle, IF2 writes type 10 and EX not-taken at the same index -> entry type 10 and counter from the IF2 rule. With different indices -> both updates visible.
REQ-035 Stall and invalidate: with stall=1 for 3 cycles while pc changes -> outputs held. An upd type 00 on a matching entry -> next lookup misses. An upd type 00 with non-matching tag -> entry retained.
REQ-036 Async reset: assert rstn=0 between edges after allocations -> outputs are 0 at once; after release every lookup misses.
